atmega_eep_sd: RTL and testbench
================================

ATMEGA_EEP_SD -- requirements
Module: atmega_eep_sd

Purpose: host-side save/load engine for the ATmega EEPROM array. It copies EEPROM contents to/from the MiSTer sector block device through a local sector buffer.

Interface
REQ-001 Parameter EEP_SIZE, default 1024, EEPROM bytes; SHALL be a multiple of 512.
REQ-002 Parameter ADDR_W, default 10, EEPROM address width; SHALL satisfy 2^ADDR_W >= EEP_SIZE.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 img_ready  in  1  level; backing image mounted.
REQ-006 save_req, load_req  in  1 each  one-cycle start pulses.
REQ-007 busy  out  1  high from the cycle after accept until DONE; done  out  1  one-cycle completion pulse.
REQ-008 eep_modified  in  1  dirty flag from the EEPROM block; eep_mod_clr  out  1  one-cycle pulse when a save starts.
REQ-009 eep_addr  out  ADDR_W; eep_wr  out  1; eep_wdata  out  8; eep_rdata  in  8, valid one cycle after eep_addr.
REQ-010 sd_lba  out  32; sd_rd, sd_wr  out  1 each; sd_ack  in  1.
REQ-011 sd_buff_addr  in  8 (16-bit word index); sd_buff_dout  in  16; sd_buff_wr  in  1; sd_buff_din  out  16.

Function
REQ-012 The block SHALL contain a 256x16 sector buffer; word w low byte = sector byte 2w, high byte = sector byte 2w+1.
REQ-013 States SHALL be IDLE, FILL, WREQ, WACK, RREQ, RACK, DRAIN, DONE, plus an internal sector counter sec (0..EEP_SIZE/512-1).
REQ-014 In IDLE, save_req or load_req SHALL be accepted only when img_ready=1; otherwise it is ignored.
REQ-015 If both pulses arrive in the same cycle, load SHALL win.
REQ-016 Any request SHALL be ignored when busy=1.
REQ-017 On save accept: sec=0, eep_mod_clr pulses for one cycle, next state FILL.
REQ-018 On load accept: sec=0, next state RREQ.
REQ-019 FILL SHALL issue eep_addr = sec*512+i for i=0..511, one per cycle, and capture eep_rdata one cycle later into the buffer; then WREQ. Duration: 513 cycles.
REQ-020 WREQ SHALL hold sd_wr=1 and sd_lba=sec until sd_ack=1, then enter WACK with sd_wr=0.
REQ-021 WACK: sd_buff_din SHALL equal buf[sd_buff_addr] registered, one-cycle latency. On sd_ack falling: if sec is last, go DONE; else sec+1 and go FILL.
REQ-022 RREQ SHALL hold sd_rd=1 and sd_lba=sec until sd_ack=1, then enter RACK with sd_rd=0.
REQ-023 RACK: buf[sd_buff_addr] <= sd_buff_dout whenever sd_buff_wr=1 and sd_ack=1. On sd_ack falling, go DRAIN.
REQ-024 DRAIN SHALL assert eep_wr=1 for 512 consecutive cycles with eep_addr=sec*512+i and eep_wdata=buffer byte i. Then: if sec is last, go DONE; else sec+1 and go RREQ.
REQ-025 DONE SHALL last one cycle, assert done=1, drop busy, and return to IDLE.
REQ-026 sd_buff_wr outside RACK SHALL be ignored. eep_wr SHALL be 0 in all states other than DRAIN.
REQ-027 img_ready falling mid-operation SHALL NOT abort; the sequence completes.
REQ-028 eep_mod_clr SHALL pulse regardless of eep_modified; the input is provided for the host policy only.

Reset
REQ-029 While rst=0, the block SHALL force: state IDLE, sec=0, busy=0, done=0, eep_wr=0, eep_mod_clr=0, sd_rd=0, sd_wr=0, sd_lba=0, eep_addr=0, eep_wdata=0, sd_buff_din=0.
REQ-030 Reset mid-operation SHALL abandon the sequence immediately; EEPROM bytes already written remain; buffer contents are undefined.

Verification
REQ-031 Save, EEP_SIZE=1024, EEPROM byte k=k[7:0], ack after 3 cycles: -> sd_wr seen with lba 0 then 1; word 5 of sector 1 reads 0x0B0A; eep_mod_clr exactly once; done once.
REQ-032 Load, EEP_SIZE=1024, host sector 0 words=0x1234, sector 1 words=0xABCD: -> EEPROM[0]=0x34, [1]=0x12, [512]=0xCD, [1023]=0xAB; 1024 eep_wr cycles total.
REQ-033 save_req and load_req in the same cycle with img_ready=1: -> sd_rd asserted, sd_wr never asserted.
REQ-034 img_ready=0 with save_req: -> busy stays 0, no sd_rd/sd_wr. save_req pulsed while busy: -> single sequence only.
REQ-035 rst=0 asserted during DRAIN of sector 0 at i=100: -> next cycle eep_wr=0 and busy=0; EEPROM[0..99] updated, [100..] unchanged; a new load then completes normally.
REQ-036 sd_ack delayed 1000 cycles in WREQ: -> sd_wr and sd_lba held stable throughout; no buffer or EEPROM activity.

Source files
------------

// File: rtl/atmega_eep_sd_if.sv
// Signal bundle between the EEPROM save/load engine and its environment
// (host control, EEPROM array port and MiSTer sector block device).
//   master : environment side (drives requests, EEPROM read data, SD ack/buffer bus)
//   slave  : engine side (atmega_eep_sd)
// Signals:
//   img_ready, save_req, load_req, busy, done      - control / status
//   eep_modified, eep_mod_clr                      - dirty-flag handshake
//   eep_addr, eep_wr, eep_wdata, eep_rdata         - EEPROM array port
//   sd_lba, sd_rd, sd_wr, sd_ack                   - sector request handshake
//   sd_buff_addr, sd_buff_dout, sd_buff_wr, sd_buff_din - sector buffer bus
interface atmega_eep_sd_if #(
    parameter int ADDR_W = 10
) ();
    logic              img_ready;
    logic              save_req;
    logic              load_req;
    logic              busy;
    logic              done;
    logic              eep_modified;
    logic              eep_mod_clr;
    logic [ADDR_W-1:0] eep_addr;
    logic              eep_wr;
    logic [7:0]        eep_wdata;
    logic [7:0]        eep_rdata;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [7:0]        sd_buff_addr;
    logic [15:0]       sd_buff_dout;
    logic              sd_buff_wr;
    logic [15:0]       sd_buff_din;

    modport master (
        output img_ready, save_req, load_req, eep_modified, eep_rdata,
               sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  busy, done, eep_mod_clr, eep_addr, eep_wr, eep_wdata,
               sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        input  img_ready, save_req, load_req, eep_modified, eep_rdata,
               sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output busy, done, eep_mod_clr, eep_addr, eep_wr, eep_wdata,
               sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/atmega_eep_sd.sv
// Save/load engine copying the ATmega EEPROM array to/from the MiSTer sector
// block device through a 256x16 local sector buffer, one 512-byte sector at a time.
// Ports:
//   clk - sole clock, rising edge
//   rst - synchronous active-low reset
//   bus - atmega_eep_sd_if.slave (control, EEPROM port, SD handshake and buffer bus)
// All outputs are registered. eep_modified is informational only for the host.
module atmega_eep_sd #(
    parameter int EEP_SIZE = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic           clk,
    input  logic           rst,
    atmega_eep_sd_if.slave bus
);
    localparam int SEC_N = EEP_SIZE / 512;
    localparam int SEC_W = (SEC_N > 1) ? $clog2(SEC_N) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WREQ  = 3'd2,
        S_WACK  = 3'd3,
        S_RREQ  = 3'd4,
        S_RACK  = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              ack_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mod_clr_q, mod_clr_d;
    logic [ADDR_W-1:0] eep_addr_q, eep_addr_d;
    logic              eep_wr_q, eep_wr_d;
    logic [7:0]        eep_wdata_q, eep_wdata_d;
    logic              sd_rd_q, sd_rd_d;
    logic              sd_wr_q, sd_wr_d;
    logic [31:0]       sd_lba_q, sd_lba_d;
    logic [15:0]       sd_buff_din_q, sd_buff_din_d;

    logic [15:0]       buf_mem [256];
    logic              fill_we_s;
    logic [8:0]        fill_idx_s;
    logic              rack_we_s;
    logic [8:0]        drain_idx_s;
    logic [15:0]       drain_word_s;
    logic [7:0]        drain_byte_s;
    logic              ack_fall_s;
    logic              unused_eep_modified_s;

    // EEPROM byte address of byte i within sector s
    function automatic logic [ADDR_W-1:0] eep_index(input logic [SEC_W-1:0] s,
                                                    input logic [8:0] i);
        return ADDR_W'({s, i});
    endfunction

    assign unused_eep_modified_s = bus.eep_modified;
    assign ack_fall_s   = ack_q & ~bus.sd_ack;
    // DRAIN presents byte cnt+1 on the next cycle; RACK exit preloads byte 0
    assign drain_idx_s  = (state_q == S_DRAIN) ? 9'(cnt_q + 10'd1) : 9'd0;
    assign drain_word_s = buf_mem[drain_idx_s[8:1]];
    assign drain_byte_s = drain_idx_s[0] ? drain_word_s[15:8] : drain_word_s[7:0];

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        sec_d         = sec_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        mod_clr_d     = 1'b0;
        eep_addr_d    = eep_addr_q;
        eep_wr_d      = 1'b0;
        eep_wdata_d   = eep_wdata_q;
        sd_rd_d       = sd_rd_q;
        sd_wr_d       = sd_wr_q;
        sd_lba_d      = sd_lba_q;
        sd_buff_din_d = sd_buff_din_q;
        fill_we_s     = 1'b0;
        fill_idx_s    = 9'd0;
        rack_we_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.img_ready && bus.load_req) begin
                    state_d  = S_RREQ;
                    sec_d    = '0;
                    busy_d   = 1'b1;
                    sd_rd_d  = 1'b1;
                    sd_lba_d = 32'd0;
                end else if (bus.img_ready && bus.save_req) begin
                    state_d    = S_FILL;
                    sec_d      = '0;
                    cnt_d      = 10'd0;
                    busy_d     = 1'b1;
                    mod_clr_d  = 1'b1;
                    eep_addr_d = eep_index('0, 9'd0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                // read data lags the address by one cycle, so cycle t stores byte t-1
                if (cnt_q != 10'd0) begin
                    fill_we_s  = 1'b1;
                    fill_idx_s = 9'(cnt_q - 10'd1);
                end else begin
                    fill_we_s  = 1'b0;
                end
                if (cnt_q == 10'd512) begin
                    state_d  = S_WREQ;
                    cnt_d    = 10'd0;
                    sd_wr_d  = 1'b1;
                    sd_lba_d = 32'(sec_q);
                end else if (cnt_q < 10'd511) begin
                    cnt_d      = cnt_q + 10'd1;
                    eep_addr_d = eep_index(sec_q, 9'(cnt_q + 10'd1));
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_WREQ: begin
                if (bus.sd_ack) begin
                    state_d = S_WACK;
                    sd_wr_d = 1'b0;
                end else begin
                    state_d = S_WREQ;
                end
            end
            S_WACK: begin
                sd_buff_din_d = buf_mem[bus.sd_buff_addr];
                if (ack_fall_s && (sec_q == SEC_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (ack_fall_s) begin
                    state_d    = S_FILL;
                    sec_d      = sec_q + SEC_W'(1);
                    cnt_d      = 10'd0;
                    eep_addr_d = eep_index(sec_q + SEC_W'(1), 9'd0);
                end else begin
                    state_d = S_WACK;
                end
            end
            S_RREQ: begin
                if (bus.sd_ack) begin
                    state_d = S_RACK;
                    sd_rd_d = 1'b0;
                end else begin
                    state_d = S_RREQ;
                end
            end
            S_RACK: begin
                rack_we_s = bus.sd_buff_wr & bus.sd_ack;
                if (ack_fall_s) begin
                    state_d     = S_DRAIN;
                    cnt_d       = 10'd0;
                    eep_wr_d    = 1'b1;
                    eep_addr_d  = eep_index(sec_q, 9'd0);
                    eep_wdata_d = drain_byte_s;
                end else begin
                    state_d = S_RACK;
                end
            end
            S_DRAIN: begin
                if (cnt_q != 10'd511) begin
                    cnt_d       = cnt_q + 10'd1;
                    eep_wr_d    = 1'b1;
                    eep_addr_d  = eep_index(sec_q, drain_idx_s);
                    eep_wdata_d = drain_byte_s;
                end else if (sec_q == SEC_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = S_RREQ;
                    sec_d    = sec_q + SEC_W'(1);
                    sd_rd_d  = 1'b1;
                    sd_lba_d = 32'(sec_q + SEC_W'(1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sec_q         <= '0;
            cnt_q         <= 10'd0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mod_clr_q     <= 1'b0;
            eep_addr_q    <= '0;
            eep_wr_q      <= 1'b0;
            eep_wdata_q   <= 8'd0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
            sd_lba_q      <= 32'd0;
            sd_buff_din_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            sec_q         <= sec_d;
            cnt_q         <= cnt_d;
            ack_q         <= bus.sd_ack;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mod_clr_q     <= mod_clr_d;
            eep_addr_q    <= eep_addr_d;
            eep_wr_q      <= eep_wr_d;
            eep_wdata_q   <= eep_wdata_d;
            sd_rd_q       <= sd_rd_d;
            sd_wr_q       <= sd_wr_d;
            sd_lba_q      <= sd_lba_d;
            sd_buff_din_q <= sd_buff_din_d;
        end
    end

    // Sector buffer writes: whole words from the SD side, single bytes from the EEPROM
    always_ff @(posedge clk) begin
        if (rack_we_s) begin
            buf_mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
        end else if (fill_we_s && fill_idx_s[0]) begin
            buf_mem[fill_idx_s[8:1]][15:8] <= bus.eep_rdata;
        end else if (fill_we_s) begin
            buf_mem[fill_idx_s[8:1]][7:0] <= bus.eep_rdata;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.eep_mod_clr = mod_clr_q;
    assign bus.eep_addr    = eep_addr_q;
    assign bus.eep_wr      = eep_wr_q;
    assign bus.eep_wdata   = eep_wdata_q;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.sd_buff_din = sd_buff_din_q;
endmodule

// File: tb/tb_atmega_eep_sd.sv
// Self-checking bench for atmega_eep_sd: EEPROM model, MiSTer host model and
// an event scoreboard (sector requests and done pulses) checked by a monitor.
module tb_atmega_eep_sd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    atmega_eep_sd_if #(.ADDR_W(10)) bus ();
    atmega_eep_sd #(.EEP_SIZE(1024), .ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    logic [7:0]  mem [1024];
    int          pre_mode  = 0;
    int          ack_delay = 3;
    logic [15:0] ld_pat [2];
    logic [15:0] cap [2][256];

    int n_eepwr = 0, n_modclr = 0, n_busy = 0, n_req = 0, n_wrrise = 0;
    logic c_rd = 1'b0, c_wr = 1'b0;
    logic m_rd = 1'b0, m_wr = 1'b0, m_done = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_%s unexpected event act=%0d exp=none", nm, act);
        end else begin
            check({"sb_", nm}, act, exp_q.pop_front());
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_done"}, 32'(bus.done), 32'd1);
    endtask

    // EEPROM model: synchronous read, write on eep_wr, bulk preload
    always @(posedge clk) begin
        if (pre_mode == 1) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 8'(k);
        end else if (pre_mode == 2) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 8'hEE;
        end else if (bus.eep_wr) begin
            mem[bus.eep_addr] <= bus.eep_wdata;
        end
        bus.eep_rdata <= mem[bus.eep_addr];
    end

    // Activity counters
    always @(posedge clk) begin
        if (bus.eep_wr) n_eepwr <= n_eepwr + 1;
        if (bus.eep_mod_clr) n_modclr <= n_modclr + 1;
        if (bus.busy) n_busy <= n_busy + 1;
        if ((bus.sd_rd && !c_rd) || (bus.sd_wr && !c_wr)) n_req <= n_req + 1;
        if (bus.sd_wr && !c_wr) n_wrrise <= n_wrrise + 1;
        c_rd <= bus.sd_rd;
        c_wr <= bus.sd_wr;
    end

    // Scoreboard monitor: codes 1000+lba write request, 2000+lba read request, 3000 done
    always @(negedge clk) begin
        if (rst) begin
            if (bus.sd_wr && !m_wr) sb_pop("wr_req", 32'd1000 + bus.sd_lba);
            if (bus.sd_rd && !m_rd) sb_pop("rd_req", 32'd2000 + bus.sd_lba);
            if (bus.done && !m_done) sb_pop("done", 32'd3000);
            if (bus.sd_rd && bus.sd_wr) check("rd_wr_overlap", 32'd1, 32'd0);
        end
        m_wr   <= bus.sd_wr;
        m_rd   <= bus.sd_rd;
        m_done <= bus.done;
    end

    // MiSTer host model: acks sector requests and moves 256 words
    initial begin : host
        logic is_wr;
        logic lba_b;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;
        bus.sd_buff_addr = 8'd0;
        bus.sd_buff_dout = 16'd0;
        forever begin
            tick();
            if (rst && (bus.sd_wr || bus.sd_rd)) begin
                is_wr = bus.sd_wr;
                lba_b = bus.sd_lba[0];
                repeat (ack_delay) tick();
                bus.sd_ack = 1'b1;
                tick();
                if (is_wr) begin
                    bus.sd_buff_addr = 8'd0;
                    for (int w = 0; w < 256; w++) begin
                        tick();
                        cap[lba_b][w]    = bus.sd_buff_din;
                        bus.sd_buff_addr = 8'(w + 1);
                    end
                end else begin
                    for (int w = 0; w < 256; w++) begin
                        bus.sd_buff_addr = 8'(w);
                        bus.sd_buff_dout = ld_pat[lba_b];
                        bus.sd_buff_wr   = 1'b1;
                        tick();
                    end
                    bus.sd_buff_wr = 1'b0;
                end
                bus.sd_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0, s1, unstable, found;
        logic [9:0]  ea;
        logic [15:0] din;
        bus.img_ready    = 1'b0;
        bus.save_req     = 1'b0;
        bus.load_req     = 1'b0;
        bus.eep_modified = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_flags", 32'({bus.done, bus.sd_rd, bus.sd_wr, bus.eep_wr, bus.eep_mod_clr}), 32'd0);
        check("rst_lba", bus.sd_lba, 32'd0);
        check("rst_eaddr_wdata", 32'({bus.eep_addr, bus.eep_wdata}), 32'd0);
        check("rst_din", 32'(bus.sd_buff_din), 32'd0);
        rst = 1'b1;
        bus.img_ready = 1'b1;
        tick();

        // Save of a k[7:0] ramp
        pre_mode = 1; tick(); pre_mode = 0; tick();
        s0 = n_modclr;
        exp_q.push_back(32'd1000); exp_q.push_back(32'd1001); exp_q.push_back(32'd3000);
        bus.save_req = 1'b1; tick(); bus.save_req = 1'b0;
        check("save_busy_rise", 32'(bus.busy), 32'd1);
        wait_done("save", 8000);
        check("save_busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        check("save_s1_w5", 32'(cap[1][5]), 32'h0B0A);
        check("save_s0_w0", 32'(cap[0][0]), 32'h0100);
        check("save_s1_w255", 32'(cap[1][255]), 32'hFFFE);
        check("save_modclr", 32'(n_modclr - s0), 32'd1);

        // Load of two patterned sectors
        pre_mode = 2; tick(); pre_mode = 0; tick();
        ld_pat[0] = 16'h1234; ld_pat[1] = 16'hABCD;
        s0 = n_eepwr;
        exp_q.push_back(32'd2000); exp_q.push_back(32'd2001); exp_q.push_back(32'd3000);
        bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
        wait_done("load", 8000);
        tick();
        check("load_mem0", 32'(mem[0]), 32'h34);
        check("load_mem1", 32'(mem[1]), 32'h12);
        check("load_mem512", 32'(mem[512]), 32'hCD);
        check("load_mem1023", 32'(mem[1023]), 32'hAB);
        check("load_wr_cycles", 32'(n_eepwr - s0), 32'd1024);

        // Simultaneous save and load: load wins
        s0 = n_wrrise;
        exp_q.push_back(32'd2000); exp_q.push_back(32'd2001); exp_q.push_back(32'd3000);
        bus.save_req = 1'b1; bus.load_req = 1'b1; tick();
        bus.save_req = 1'b0; bus.load_req = 1'b0;
        wait_done("both", 8000);
        tick();
        check("both_no_wr", 32'(n_wrrise - s0), 32'd0);

        // No image mounted: request ignored
        bus.img_ready = 1'b0;
        s0 = n_busy; s1 = n_req;
        bus.save_req = 1'b1; tick(); bus.save_req = 1'b0;
        repeat (20) tick();
        check("noimg_busy", 32'(n_busy - s0), 32'd0);
        check("noimg_req", 32'(n_req - s1), 32'd0);
        bus.img_ready = 1'b1;

        // Requests while busy are ignored; mod_clr pulses although eep_modified is set
        bus.eep_modified = 1'b1;
        s0 = n_modclr;
        exp_q.push_back(32'd1000); exp_q.push_back(32'd1001); exp_q.push_back(32'd3000);
        bus.save_req = 1'b1; tick(); bus.save_req = 1'b0;
        repeat (5) tick();
        bus.save_req = 1'b1; bus.load_req = 1'b1; tick();
        bus.save_req = 1'b0; bus.load_req = 1'b0;
        repeat (600) tick();
        bus.save_req = 1'b1; tick(); bus.save_req = 1'b0;
        wait_done("rebusy", 8000);
        repeat (50) tick();
        check("rebusy_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rebusy_modclr", 32'(n_modclr - s0), 32'd1);
        bus.eep_modified = 1'b0;

        // Reset during DRAIN of sector 0: bytes 0..99 written, rest untouched
        pre_mode = 2; tick(); pre_mode = 0; tick();
        ld_pat[0] = 16'h1111; ld_pat[1] = 16'h1111;
        exp_q.push_back(32'd2000);
        bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            if (bus.eep_wr && bus.eep_addr == 10'd99) found = 1;
            else tick();
        end
        check("drain_reached", 32'(found), 32'd1);
        rst = 1'b0; tick();
        check("rst_drain_wr", 32'(bus.eep_wr), 32'd0);
        check("rst_drain_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1; tick();
        check("rst_mem0", 32'(mem[0]), 32'h11);
        check("rst_mem99", 32'(mem[99]), 32'h11);
        check("rst_mem100", 32'(mem[100]), 32'hEE);
        check("rst_mem511", 32'(mem[511]), 32'hEE);
        ld_pat[0] = 16'h2222; ld_pat[1] = 16'h3333;
        exp_q.push_back(32'd2000); exp_q.push_back(32'd2001); exp_q.push_back(32'd3000);
        bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
        wait_done("reload", 8000);
        tick();
        check("reload_mem100", 32'(mem[100]), 32'h22);
        check("reload_mem1023", 32'(mem[1023]), 32'h33);

        // Long ack delay in WREQ: request held, no buffer/EEPROM activity
        ack_delay = 1000;
        exp_q.push_back(32'd1000); exp_q.push_back(32'd1001); exp_q.push_back(32'd3000);
        bus.save_req = 1'b1; tick(); bus.save_req = 1'b0;
        found = 0;
        for (int n = 0; n < 1000 && found == 0; n++) begin
            if (bus.sd_wr) found = 1;
            else tick();
        end
        check("slow_wreq_seen", 32'(found), 32'd1);
        ea = bus.eep_addr; din = bus.sd_buff_din; unstable = 0;
        repeat (990) begin
            tick();
            if (!bus.sd_wr || bus.sd_lba != 32'd0 || bus.eep_wr ||
                bus.eep_addr != ea || bus.sd_buff_din != din) unstable++;
        end
        check("slow_wreq_stable", 32'(unstable), 32'd0);
        wait_done("slow", 12000);
        ack_delay = 3;

        repeat (5) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
